// File: rtl/udp_port_register_sink_if.sv
// UDP header + payload stream bundle feeding udp_port_register_sink.
// The master side is the UDP RX path (header/payload source). The slave side is the sink.
interface udp_port_register_sink_if;
   logic        s_udp_hdr_valid;
   logic        s_udp_hdr_ready;
   logic [15:0] s_udp_dest_port;
   logic [7:0]  s_payload_tdata;
   logic        s_payload_tvalid;
   logic        s_payload_tready;
   logic        s_payload_tlast;
   logic        s_payload_tuser;

   modport master (
      output s_udp_hdr_valid,
      output s_udp_dest_port,
      output s_payload_tdata,
      output s_payload_tvalid,
      output s_payload_tlast,
      output s_payload_tuser,
      input  s_udp_hdr_ready,
      input  s_payload_tready
   );

   modport slave (
      input  s_udp_hdr_valid,
      input  s_udp_dest_port,
      input  s_payload_tdata,
      input  s_payload_tvalid,
      input  s_payload_tlast,
      input  s_payload_tuser,
      output s_udp_hdr_ready,
      output s_payload_tready
   );
endinterface

// File: rtl/udp_port_register_sink.sv
// udp_port_register_sink
// Demultiplexes received UDP datagrams by destination port onto NUM_CHANNELS
// register channels (ports BASE_PORT .. BASE_PORT+NUM_CHANNELS-1). The first REG_BYTES
// payload bytes of each good datagram are captured little-endian into that channel.
// Optional feature: define UDP_PORT_SINK_STATS_EN to add the stat_accept_count and
// stat_drop_count counters and ports.
module udp_port_register_sink #(
   parameter int NUM_CHANNELS = 4,
   parameter int BASE_PORT    = 3000,
   parameter int REG_BYTES    = 1
) (
   input  logic                                udp_sys_clk,
   input  logic                                system_reset,
   udp_port_register_sink_if.slave             s_udp,
   output logic [NUM_CHANNELS*REG_BYTES*8-1:0] chan_data,
   output logic [NUM_CHANNELS-1:0]             chan_update,
   output logic                                busy
`ifdef UDP_PORT_SINK_STATS_EN
   ,
   output logic [15:0]                         stat_accept_count,
   output logic [15:0]                         stat_drop_count
`endif
);

   localparam int REG_W = REG_BYTES * 8;
   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int CNT_W = $clog2(REG_BYTES + 1);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DROP
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] chan_idx;
   logic [CNT_W-1:0] byte_count;
   logic [CNT_W:0]   bytes_seen;
   logic [REG_W-1:0] shadow;
   logic [REG_W-1:0] shadow_next;
   logic [16:0]      port_offset;
   logic             port_in_range;
   logic             hdr_fire;
   logic             beat_fire;
   logic             last_fire;
   logic             datagram_commit;

   // The offset is taken in 17 bits so ports below BASE_PORT show up as negative.
   assign port_offset   = {1'b0, s_udp.s_udp_dest_port} - 17'(BASE_PORT);
   assign port_in_range = !port_offset[16] && (port_offset < 17'(NUM_CHANNELS));

   assign hdr_fire  = s_udp.s_udp_hdr_valid && s_udp.s_udp_hdr_ready;
   assign beat_fire = s_udp.s_payload_tvalid && s_udp.s_payload_tready;
   assign last_fire = beat_fire && s_udp.s_payload_tlast;

   // Byte count including the beat currently on the bus; commits need a full register.
   assign bytes_seen      = {1'b0, byte_count} + (CNT_W + 1)'(1);
   assign datagram_commit = (state == CAPTURE) && last_fire && !s_udp.s_payload_tuser &&
                            (bytes_seen >= (CNT_W + 1)'(REG_BYTES));

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge udp_sys_clk or posedge system_reset) begin
      if (system_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake readies: header only in IDLE, payload only inside a datagram.
   always_comb begin
      state_next             = state;
      s_udp.s_udp_hdr_ready  = 1'b0;
      s_udp.s_payload_tready = 1'b0;
      case (state)
         IDLE: begin
            s_udp.s_udp_hdr_ready = 1'b1;
            if (s_udp.s_udp_hdr_valid) begin
               state_next = port_in_range ? CAPTURE : DROP;
            end
         end
         CAPTURE, DROP: begin
            s_udp.s_payload_tready = 1'b1;
            if (s_udp.s_payload_tvalid && s_udp.s_payload_tlast) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shadow register with the current beat merged in at the byte counter position.
   always_comb begin
      shadow_next = shadow;
      for (int k = 0; k < REG_BYTES; k++) begin
         if (byte_count == CNT_W'(k)) begin
            shadow_next[k*8 +: 8] = s_udp.s_payload_tdata;
         end
      end
   end

   // Capture path: latch the channel and clear shadow/counter on header, then fill bytes.
   always_ff @(posedge udp_sys_clk or posedge system_reset) begin
      if (system_reset) begin
         chan_idx   <= '0;
         byte_count <= '0;
         shadow     <= '0;
      end else if (hdr_fire) begin
         chan_idx   <= port_offset[IDX_W-1:0];
         byte_count <= '0;
         shadow     <= '0;
      end else if ((state == CAPTURE) && beat_fire) begin
         shadow <= shadow_next;
         if (byte_count != CNT_W'(REG_BYTES)) begin
            byte_count <= byte_count + CNT_W'(1);
         end
      end
   end

   // Commit the completed shadow into the selected channel and pulse its update flag.
   always_ff @(posedge udp_sys_clk or posedge system_reset) begin
      if (system_reset) begin
         chan_data   <= '0;
         chan_update <= '0;
      end else begin
         chan_update <= '0;
         if (datagram_commit) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               if (chan_idx == IDX_W'(i)) begin
                  chan_data[i*REG_W +: REG_W] <= shadow_next;
                  chan_update[i]              <= 1'b1;
               end
            end
         end
      end
   end

`ifdef UDP_PORT_SINK_STATS_EN
   logic datagram_drop;

   assign datagram_drop = last_fire && !datagram_commit;

   // Wrapping accept/drop counters, each datagram counted once when its last beat lands.
   always_ff @(posedge udp_sys_clk or posedge system_reset) begin
      if (system_reset) begin
         stat_accept_count <= '0;
         stat_drop_count   <= '0;
      end else begin
         if (datagram_commit) begin
            stat_accept_count <= stat_accept_count + 16'd1;
         end
         if (datagram_drop) begin
            stat_drop_count <= stat_drop_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_udp_port_register_sink.sv
// Scoreboard bench for udp_port_register_sink (NUM_CHANNELS=4, BASE_PORT=3000, REG_BYTES=2).
// Header and payload are driven by independent randomised drivers; a negedge monitor
// checks channel updates, register contents and readies against a datagram-level model.
module tb_udp_port_register_sink;

   localparam int NCH  = 4;
   localparam int BASE = 3000;
   localparam int RB   = 2;
   localparam int RW   = RB * 8;

   logic              udp_sys_clk = 1'b0;
   logic              system_reset;
   logic [NCH*RW-1:0] chan_data;
   logic [NCH-1:0]    chan_update;
   logic              busy;
`ifdef UDP_PORT_SINK_STATS_EN
   logic [15:0]       stat_accept_count;
   logic [15:0]       stat_drop_count;
`endif

   udp_port_register_sink_if bus();

   udp_port_register_sink #(
      .NUM_CHANNELS (NCH),
      .BASE_PORT    (BASE),
      .REG_BYTES    (RB)
   ) dut (
      .udp_sys_clk       (udp_sys_clk),
      .system_reset      (system_reset),
      .s_udp             (bus),
      .chan_data         (chan_data),
      .chan_update       (chan_update),
      .busy              (busy)
`ifdef UDP_PORT_SINK_STATS_EN
      ,
      .stat_accept_count (stat_accept_count),
      .stat_drop_count   (stat_drop_count)
`endif
   );

   // Free-running clock.
   always #5 udp_sys_clk = ~udp_sys_clk;

   logic [15:0]   hdrQ[$];
   logic [10:0]   beatQ[$];
   int            expChQ[$];
   logic [RW-1:0] expValQ[$];
   logic [RW-1:0] chanModel[NCH];
   int            acceptModel = 0;
   int            dropModel = 0;
   int            compareCount = 0;
   int            mismatchCount = 0;
   bit            hdrIdle = 1'b1;
   bit            payIdle = 1'b1;
   bit            curGood = 1'b0;
   bit            inPkt = 1'b0;
   bit            lastGoodPending = 1'b0;
   int            monCh;
   logic [RW-1:0] monVal;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Queue one datagram and record its expected outcome from the port/length/error rules.
   task automatic applyStimulus(input logic [15:0] port, input int len, input logic [31:0] bytesLe,
                                input bit user);
      int            ch;
      bit            good;
      logic [RW-1:0] val;
      logic [7:0]    b;
      bit            last;
      bit            u;
      ch   = int'(port) - BASE;
      good = (ch >= 0) && (ch < NCH) && !user && (len >= RB);
      val  = '0;
      for (int k = 0; k < RB; k++) begin
         b = bytesLe[k*8 +: 8];
         val = val | (RW'(b) << (8 * k));
      end
      if (good) begin
         expChQ.push_back(ch);
         expValQ.push_back(val);
         acceptModel++;
      end else begin
         dropModel++;
      end
      hdrQ.push_back(port);
      for (int k = 0; k < len; k++) begin
         last = (k == len - 1);
         u    = last ? user : 1'($urandom_range(0, 1));
         beatQ.push_back({good && last, last, u, bytesLe[k*8 +: 8]});
      end
   endtask

   function automatic logic [NCH*RW-1:0] modelFlat();
      logic [NCH*RW-1:0] r;
      for (int i = 0; i < NCH; i++) begin
         r[i*RW +: RW] = chanModel[i];
      end
      return r;
   endfunction

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (!(hdrQ.size() == 0 && beatQ.size() == 0 && hdrIdle && payIdle && !busy) && n < 5000) begin
         @(posedge udp_sys_clk);
         n++;
      end
      checkOutput({tag, "_drain_timeout"}, 64'(n >= 5000), 64'd0);
      repeat (3) @(posedge udp_sys_clk);
      #1;
   endtask

   // Header driver: offers queued headers with random gaps, holding each until accepted.
   initial begin
      bus.s_udp_hdr_valid = 1'b0;
      bus.s_udp_dest_port = '0;
      @(posedge udp_sys_clk);
      #1;
      forever begin
         if (hdrQ.size() == 0 || $urandom_range(0, 2) == 0) begin
            hdrIdle = (hdrQ.size() == 0);
            bus.s_udp_hdr_valid = 1'b0;
            @(posedge udp_sys_clk);
            #1;
         end else begin
            hdrIdle = 1'b0;
            bus.s_udp_dest_port = hdrQ.pop_front();
            bus.s_udp_hdr_valid = 1'b1;
            forever begin
               @(negedge udp_sys_clk);
               if (bus.s_udp_hdr_ready) break;
            end
            @(posedge udp_sys_clk);
            #1;
         end
      end
   end

   // Payload driver: offers queued beats with random gaps, holding each until accepted.
   initial begin
      logic [10:0] beat;
      bus.s_payload_tvalid = 1'b0;
      bus.s_payload_tdata  = '0;
      bus.s_payload_tlast  = 1'b0;
      bus.s_payload_tuser  = 1'b0;
      @(posedge udp_sys_clk);
      #1;
      forever begin
         if (beatQ.size() == 0 || $urandom_range(0, 3) == 0) begin
            payIdle = (beatQ.size() == 0);
            bus.s_payload_tvalid = 1'b0;
            curGood = 1'b0;
            @(posedge udp_sys_clk);
            #1;
         end else begin
            payIdle = 1'b0;
            beat = beatQ.pop_front();
            curGood              = beat[10];
            bus.s_payload_tlast  = beat[9];
            bus.s_payload_tuser  = beat[8];
            bus.s_payload_tdata  = beat[7:0];
            bus.s_payload_tvalid = 1'b1;
            forever begin
               @(negedge udp_sys_clk);
               if (bus.s_payload_tready) break;
            end
            @(posedge udp_sys_clk);
            #1;
         end
      end
   end

   // Monitor: update pulses one cycle after a good tlast, registers match the model,
   // readies follow the header/tlast handshakes.
   initial begin
      forever begin
         @(negedge udp_sys_clk);
         if (system_reset) begin
            for (int i = 0; i < NCH; i++) chanModel[i] = '0;
            inPkt = 1'b0;
            lastGoodPending = 1'b0;
         end else begin
            if (lastGoodPending || chan_update != '0) begin
               if (expChQ.size() == 0) begin
                  checkOutput("spurious_update", 64'(chan_update), 64'd0);
               end else begin
                  monCh  = expChQ.pop_front();
                  monVal = expValQ.pop_front();
                  checkOutput("update_pulse", 64'(chan_update), 64'd1 << monCh);
                  chanModel[monCh] = monVal;
               end
            end
            checkOutput("chan_data", 64'(chan_data), 64'(modelFlat()));
            checkOutput("busy_readies", 64'({busy, bus.s_udp_hdr_ready, bus.s_payload_tready}),
                        inPkt ? 64'd5 : 64'd2);
            lastGoodPending = bus.s_payload_tvalid && bus.s_payload_tready && bus.s_payload_tlast && curGood;
            if (bus.s_udp_hdr_valid && bus.s_udp_hdr_ready) begin
               inPkt = 1'b1;
            end else if (bus.s_payload_tvalid && bus.s_payload_tready && bus.s_payload_tlast) begin
               inPkt = 1'b0;
            end
         end
      end
   end

   // Main sequence: reset, directed datagrams, reset mid-capture, then random traffic.
   initial begin
      int            n;
      logic [15:0]   port;
      int            sel;
      for (int i = 0; i < NCH; i++) chanModel[i] = '0;
      system_reset = 1'b1;
      repeat (3) @(posedge udp_sys_clk);
      #2;
      checkOutput("reset_chan_data", 64'(chan_data), 64'd0);
      checkOutput("reset_chan_update", 64'(chan_update), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_hdr_ready", 64'(bus.s_udp_hdr_ready), 64'd1);
      checkOutput("reset_tready", 64'(bus.s_payload_tready), 64'd0);
      system_reset = 1'b0;

      $display("[TB] directed datagrams");
      applyStimulus(16'd3003, 3, 32'h00C3B2A1, 1'b0);
      applyStimulus(16'd2999, 2, 32'h00005A5A, 1'b0);
      applyStimulus(16'd3004, 3, 32'h00123456, 1'b0);
      applyStimulus(16'd3001, 1, 32'h00000011, 1'b0);
      applyStimulus(16'd3001, 2, 32'h00003322, 1'b1);
      applyStimulus(16'd3000, 2, 32'h00000605, 1'b0);
      applyStimulus(16'd0,    2, 32'h0000BEEF, 1'b0);
      waitIdle("directed");
`ifdef UDP_PORT_SINK_STATS_EN
      checkOutput("directed_accept_count", 64'(stat_accept_count), 64'(acceptModel[15:0]));
      checkOutput("directed_drop_count", 64'(stat_drop_count), 64'(dropModel[15:0]));
`endif

      $display("[TB] reset during capture on port 3002");
      hdrQ.push_back(16'd3002);
      beatQ.push_back({3'b000, 8'h10});
      beatQ.push_back({3'b000, 8'h20});
      n = 0;
      while (!(busy && hdrQ.size() == 0 && beatQ.size() == 0 && payIdle) && n < 1000) begin
         @(posedge udp_sys_clk);
         n++;
      end
      checkOutput("capture_reach_timeout", 64'(n >= 1000), 64'd0);
      @(posedge udp_sys_clk);
      #3;
      system_reset = 1'b1;
      #1;
      checkOutput("midreset_chan_data", 64'(chan_data), 64'd0);
      checkOutput("midreset_chan_update", 64'(chan_update), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_tready", 64'(bus.s_payload_tready), 64'd0);
      acceptModel = 0;
      dropModel   = 0;
      repeat (2) @(posedge udp_sys_clk);
      #1;
      system_reset = 1'b0;
      applyStimulus(16'd3002, 2, 32'h0000007F, 1'b0);
      waitIdle("after_reset");

      $display("[TB] random traffic");
      for (int p = 0; p < 60; p++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)       port = 16'(BASE + $urandom_range(0, NCH - 1));
         else if (sel == 6) port = 16'(BASE - 1);
         else if (sel == 7) port = 16'(BASE + NCH);
         else               port = 16'($urandom);
         applyStimulus(port, $urandom_range(1, 4), $urandom, ($urandom_range(0, 5) == 0));
      end
      waitIdle("random");
      checkOutput("expected_queue_empty", 64'(expChQ.size()), 64'd0);
`ifdef UDP_PORT_SINK_STATS_EN
      checkOutput("final_accept_count", 64'(stat_accept_count), 64'(acceptModel[15:0]));
      checkOutput("final_drop_count", 64'(stat_drop_count), 64'(dropModel[15:0]));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
